// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: FSM state encoding,
// frame constants and error codes.
// Optional feature macro: UART_CMD_CHECKSUM_EN (adds the GET_CHK state).
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
`ifdef UART_CMD_CHECKSUM_EN
    GET_CHK,
`endif
    EXEC,
    WAIT_RD,
    RESPOND
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_BAD_CMD      = 3'd1;
  localparam logic [2:0] ERR_CHECKSUM     = 3'd2;
  localparam logic [2:0] ERR_BYTE_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_READ_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN      = 3'd5;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Idle-gap timeout counter for the UART command controller.
// Ports:
//   i_Clock   clock
//   i_Reset   synchronous active-high reset
//   i_Clear   clear the count (qualifying event or state change)
//   i_Run     count this cycle (timed state with no qualifying event)
//   o_Expired high for the cycle in which the count reaches TIMEOUT_CLKS-1
//             while running; the controller leaves the timed state on it,
//             which clears the count, so it lasts one cycle.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CLKS = 17360
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Run,
  output logic o_Expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear) begin
      count <= '0;
    end else if (i_Run) begin
      count <= count + 1'b1;
    end
  end

  assign o_Expired = i_Run && (count == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame-level command controller behind the UART receiver. Assembles
// SYNC/CMD/ADDR/DATA[/CHK] frames, issues single register writes/reads,
// returns read data as a one-byte response and reports framing errors.
// Optional feature macro: UART_CMD_CHECKSUM_EN (5-byte frame with CHK byte;
// undefined gives a 4-byte frame and no checksum error).
// Ports:
//   i_Clock, i_Reset           clock, synchronous active-high reset
//   i_RX_DV, i_RX_Byte         received byte strobe and data
//   o_Wr_En, o_Rd_En           one-cycle register write/read strobes
//   o_Addr, o_Wr_Data          register address (held) and write data
//   i_Rd_Valid, i_Rd_Data      read data return
//   o_Resp_DV, o_Resp_Byte     response strobe and byte (held)
//   o_Err, o_Err_Code          error strobe and cause (held)
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Wr_En,
  output logic       o_Rd_En,
  output logic [7:0] o_Addr,
  output logic [7:0] o_Wr_Data,
  input  logic       i_Rd_Valid,
  input  logic [7:0] i_Rd_Data,
  output logic       o_Resp_DV,
  output logic [7:0] o_Resp_Byte,
  output logic       o_Err,
  output logic [2:0] o_Err_Code
);

  state_t     state, next_state;
  logic [7:0] cmd_q, addr_q, data_q;
  logic       evt, run, expired;
  logic       err_d;
  logic [2:0] err_code_d;
  logic [7:0] exec_data;

  uart_cmd_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (evt || (next_state != state)),
    .i_Run     (run),
    .o_Expired (expired)
  );

  always_comb begin
    next_state = state;
    evt        = 1'b0;
    run        = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    case (state)
      IDLE: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) next_state = GET_CMD;
      end
      GET_CMD: begin
        evt = i_RX_DV;
        if (i_RX_DV) begin
          if ((i_RX_Byte == CMD_WR) || (i_RX_Byte == CMD_RD)) begin
            next_state = GET_ADDR;
          end else begin
            next_state = IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_BAD_CMD;
          end
        end
      end
      GET_ADDR: begin
        evt = i_RX_DV;
        if (i_RX_DV) next_state = GET_DATA;
      end
      GET_DATA: begin
        evt = i_RX_DV;
`ifdef UART_CMD_CHECKSUM_EN
        if (i_RX_DV) next_state = GET_CHK;
`else
        if (i_RX_DV) next_state = EXEC;
`endif
      end
`ifdef UART_CMD_CHECKSUM_EN
      GET_CHK: begin
        evt = i_RX_DV;
        if (i_RX_DV) begin
          if (i_RX_Byte == (cmd_q ^ addr_q ^ data_q)) begin
            next_state = EXEC;
          end else begin
            next_state = IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_CHECKSUM;
          end
        end
      end
`endif
      EXEC: begin
        next_state = (cmd_q == CMD_RD) ? WAIT_RD : IDLE;
      end
      WAIT_RD: begin
        evt = i_Rd_Valid;
        if (i_Rd_Valid) next_state = RESPOND;
      end
      RESPOND: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // A byte landing while a command is executing is dropped and flagged.
    if (i_RX_DV && ((state == EXEC) || (state == WAIT_RD) || (state == RESPOND))) begin
      err_d      = 1'b1;
      err_code_d = ERR_OVERRUN;
    end

    // Count only on cycles without a qualifying event, so an event always
    // beats an expiry in the same cycle.
    run = (state inside {GET_CMD, GET_ADDR, GET_DATA, WAIT_RD}
`ifdef UART_CMD_CHECKSUM_EN
           || (state == GET_CHK)
`endif
          ) && !evt;
    if (expired) begin
      next_state = IDLE;
      err_d      = 1'b1;
      err_code_d = (state == WAIT_RD) ? ERR_READ_TIMEOUT : ERR_BYTE_TIMEOUT;
    end
  end

  // Without the CHK byte, EXEC is entered on the DATA byte itself.
  assign exec_data = (state == GET_DATA) ? i_RX_Byte : data_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      o_Wr_En     <= 1'b0;
      o_Rd_En     <= 1'b0;
      o_Addr      <= 8'h00;
      o_Wr_Data   <= 8'h00;
      o_Resp_DV   <= 1'b0;
      o_Resp_Byte <= 8'h00;
      o_Err       <= 1'b0;
      o_Err_Code  <= ERR_NONE;
    end else begin
      state     <= next_state;
      o_Wr_En   <= (next_state == EXEC) && (cmd_q == CMD_WR);
      o_Rd_En   <= (next_state == EXEC) && (cmd_q == CMD_RD);
      o_Resp_DV <= (next_state == RESPOND);
      o_Err     <= err_d;
      if (err_d) o_Err_Code <= err_code_d;
      if (next_state == EXEC) begin
        o_Addr <= addr_q;
        if (cmd_q == CMD_WR) o_Wr_Data <= exec_data;
      end
      if (next_state == RESPOND) o_Resp_Byte <= i_Rd_Data;
    end
  end

  // Frame field capture; these are pure data and need no reset.
  always_ff @(posedge i_Clock) begin
    if (i_RX_DV) begin
      if (state == GET_CMD)  cmd_q  <= i_RX_Byte;
      if (state == GET_ADDR) addr_q <= i_RX_Byte;
      if (state == GET_DATA) data_q <= i_RX_Byte;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rd_valid = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       o_Wr_En, o_Rd_En, o_Resp_DV, o_Err;
  logic [7:0] o_Addr, o_Wr_Data, o_Resp_Byte;
  logic [2:0] o_Err_Code;

  uart_cmd_ctrl #(.CLKS_PER_BIT(2), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_Wr_En     (o_Wr_En),
    .o_Rd_En     (o_Rd_En),
    .o_Addr      (o_Addr),
    .o_Wr_Data   (o_Wr_Data),
    .i_Rd_Valid  (rd_valid),
    .i_Rd_Data   (rd_data),
    .o_Resp_DV   (o_Resp_DV),
    .o_Resp_Byte (o_Resp_Byte),
    .o_Err       (o_Err),
    .o_Err_Code  (o_Err_Code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_cyc = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t resp_q[$];
  exp_t err_q[$];

  // Scoreboard: every strobe is matched against the oldest expected event.
  exp_t ew, er, es, ee;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_Wr_En) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr=%02h data=%02h at cyc %0d, required no write", o_Addr, o_Wr_Data, cyc);
        end else begin
          ew = wr_q.pop_front();
          if (o_Addr !== ew.a || o_Wr_Data !== ew.d || cyc != ew.cyc) begin
            errors++;
            $display("FAIL wr: got addr=%02h data=%02h cyc=%0d, required addr=%02h data=%02h cyc=%0d", o_Addr, o_Wr_Data, cyc, ew.a, ew.d, ew.cyc);
          end
        end
      end
      if (o_Rd_En) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got addr=%02h at cyc %0d, required no read", o_Addr, cyc);
        end else begin
          er = rd_q.pop_front();
          if (o_Addr !== er.a || cyc != er.cyc) begin
            errors++;
            $display("FAIL rd: got addr=%02h cyc=%0d, required addr=%02h cyc=%0d", o_Addr, cyc, er.a, er.cyc);
          end
        end
      end
      if (o_Resp_DV) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got byte=%02h at cyc %0d, required no response", o_Resp_Byte, cyc);
        end else begin
          es = resp_q.pop_front();
          if (o_Resp_Byte !== es.d || cyc != es.cyc) begin
            errors++;
            $display("FAIL resp: got byte=%02h cyc=%0d, required byte=%02h cyc=%0d", o_Resp_Byte, cyc, es.d, es.cyc);
          end
        end
      end
      if (o_Err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected: got code=%0d at cyc %0d, required no error", o_Err_Code, cyc);
        end else begin
          ee = err_q.pop_front();
          if (o_Err_Code !== ee.d[2:0] || cyc != ee.cyc) begin
            errors++;
            $display("FAIL err: got code=%0d cyc=%0d, required code=%0d cyc=%0d", o_Err_Code, cyc, ee.d[2:0], ee.cyc);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    last_cyc = cyc + 1;  // cyc's own update for this edge is still pending
    #1;
    rx_dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(addr);
    send_byte(data);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(cmd ^ addr ^ data);
`endif
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    send_frame(8'h01, addr, data);
    wr_q.push_back('{addr, data, last_cyc});
  endtask

  // Read with i_Rd_Valid sampled 'delay' edges after the final frame byte
  // (delay >= 2); a decoy i_Rd_Valid during the o_Rd_En cycle must be ignored.
  task automatic do_read(input logic [7:0] addr, input logic [7:0] rdata, input int delay);
    int n;
    send_frame(8'h02, addr, 8'h00);
    n = last_cyc;
    rd_q.push_back('{addr, 8'h00, n});
    rd_valid = 1'b1;
    rd_data  = ~rdata;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    repeat (delay - 2) @(posedge clk);
    #1;
    resp_q.push_back('{8'h00, rdata, n + delay});
    rd_valid = 1'b1;
    rd_data  = rdata;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
  endtask

  task automatic check_drain(input string name);
    int n;
    n = 0;
    while ((wr_q.size() + rd_q.size() + resp_q.size() + err_q.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    checks++;
    if ((wr_q.size() + rd_q.size() + resp_q.size() + err_q.size()) != 0) begin
      errors++;
      $display("FAIL %s_pending: wr=%0d rd=%0d resp=%0d err=%0d outstanding, required all 0", name, wr_q.size(), rd_q.size(), resp_q.size(), err_q.size());
    end
    wr_q.delete();
    rd_q.delete();
    resp_q.delete();
    err_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    @(negedge clk);
    checks++;
    if ({o_Wr_En, o_Rd_En, o_Resp_DV, o_Err} !== 4'b0) begin
      errors++;
      $display("FAIL %s_strobes: got wr=%b rd=%b resp=%b err=%b, required all 0", name, o_Wr_En, o_Rd_En, o_Resp_DV, o_Err);
    end
    checks++;
    if ({o_Addr, o_Wr_Data, o_Resp_Byte, o_Err_Code} !== 27'd0) begin
      errors++;
      $display("FAIL %s_data: got addr=%02h wdata=%02h resp=%02h code=%0d, required all 0", name, o_Addr, o_Wr_Data, o_Resp_Byte, o_Err_Code);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_write();
    do_write(8'h10, 8'h5C);
    check_drain("write");
  endtask

  task automatic test_read();
    do_read(8'h20, 8'h3C, 3);
    check_drain("read");
  endtask

  task automatic test_checksum();
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h5C);
    send_byte(8'h00);
    err_q.push_back('{8'h00, 8'd2, last_cyc});
`else
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h5C);
    wr_q.push_back('{8'h10, 8'h5C, last_cyc});
    send_byte(8'h00);
`endif
    do_write(8'h11, 8'h22);
    check_drain("checksum");
  endtask

  task automatic test_bad_cmd();
    send_byte(8'hA5);
    send_byte(8'h07);
    err_q.push_back('{8'h00, 8'd1, last_cyc});
    check_drain("bad_cmd");
    send_byte(8'h00);
    send_byte(8'hFF);
    do_write(8'h10, 8'h5C);
    check_drain("resync");
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
    err_q.push_back('{8'h00, 8'd3, last_cyc + TMO});
    check_drain("byte_timeout");
    send_frame(8'h02, 8'h33, 8'h00);
    rd_q.push_back('{8'h33, 8'h00, last_cyc});
    err_q.push_back('{8'h00, 8'd4, last_cyc + 1 + TMO});
    check_drain("read_timeout");
  endtask

  task automatic test_overrun();
    int n;
    send_frame(8'h02, 8'h44, 8'h00);
    n = last_cyc;
    rd_q.push_back('{8'h44, 8'h00, n});
    send_byte(8'h55);
    err_q.push_back('{8'h00, 8'd5, last_cyc});
    @(posedge clk);
    #1;
    resp_q.push_back('{8'h00, 8'hC3, cyc + 1});
    rd_valid = 1'b1;
    rd_data  = 8'hC3;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    check_drain("overrun");
  endtask

  task automatic test_back_to_back();
    do_write(8'h01, 8'hAA);
    do_write(8'h02, 8'h55);
    do_read(8'h7E, 8'h81, 2);
    do_write(8'hFF, 8'h00);
    check_drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_outputs_zero("reset_mid_frame");
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_write(8'h66, 8'h99);
    check_drain("after_reset_frame");
    send_frame(8'h02, 8'h12, 8'h00);
    rd_q.push_back('{8'h12, 8'h00, last_cyc});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_outputs_zero("reset_mid_read");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_valid = 1'b1;
    rd_data  = 8'h5A;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    do_write(8'h67, 8'h98);
    check_drain("after_reset_read");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_checksum();
    test_bad_cmd();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame-level command controller sitting directly behind the UART receiver on the De10-Lite peripheral path. It consumes the receiver's one-cycle byte strobes, assembles fixed-length command frames, and sequences single register writes and reads on the peripheral register port. It returns read data as a one-byte response strobe for the UART transmitter and reports framing errors.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clocks per UART bit; used only to size the default timeout.
- TIMEOUT_CLKS, 20*CLKS_PER_BIT: idle clocks allowed between frame bytes, and while waiting for read data, before aborting.

Ports:
- i_Clock  in  1  the single clock; everything is synchronous to its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_RX_DV  in  1  one-cycle strobe for a received byte.
- i_RX_Byte  in  8  received byte; valid only while i_RX_DV is high.
- o_Wr_En  out  1  one-cycle register write strobe.
- o_Rd_En  out  1  one-cycle register read strobe.
- o_Addr  out  8  register address; held stable from the strobe until the next frame's EXEC.
- o_Wr_Data  out  8  write data; valid while o_Wr_En is high.
- i_Rd_Valid  in  1  read data is valid this cycle.
- i_Rd_Data  in  8  read data.
- o_Resp_DV  out  1  one-cycle response strobe to the transmitter.
- o_Resp_Byte  out  8  response byte; held until the next response.
- o_Err  out  1  one-cycle error strobe.
- o_Err_Code  out  3  error cause; held until the next error.

## Operation
Frame format: SYNC 0xA5, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
- CMD 0x01 is a write. CMD 0x02 is a read; its DATA byte is received and ignored.

States: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, WAIT_RD, RESPOND.
- IDLE: a byte equal to 0xA5 moves to GET_CMD. Any other byte is discarded silently, with no error (resync).
- GET_CMD: CMD 0x01 or 0x02 moves to GET_ADDR. Any other CMD raises error 1 and returns to IDLE.
- GET_ADDR moves to GET_DATA. GET_DATA moves to GET_CHK.
- GET_CHK: a checksum mismatch raises error 2 and returns to IDLE. A match moves to EXEC.
- EXEC, write: pulse o_Wr_En, then return to IDLE.
- EXEC, read: pulse o_Rd_En, then go to WAIT_RD.
- WAIT_RD: i_Rd_Valid captures i_Rd_Data and moves to RESPOND.
- RESPOND: pulse o_Resp_DV, then return to IDLE.

Timeout:
- In GET_* and WAIT_RD, a counter increments on every cycle that has no qualifying event (i_RX_DV in GET_*, i_Rd_Valid in WAIT_RD).
- The counter clears on each qualifying event and on every state change.
- At TIMEOUT_CLKS-1 the block raises error 3 (byte gap) or error 4 (read), then returns to IDLE.
- Counter width is $clog2(TIMEOUT_CLKS+1) bits.

Overrun: i_RX_DV in EXEC, WAIT_RD or RESPOND drops the byte and raises error 5. The operation in progress continues.

Error codes: 0 none, 1 bad CMD, 2 checksum, 3 byte timeout, 4 read timeout, 5 overrun.

## Timing
- Reset values: all strobes 0, o_Addr/o_Wr_Data/o_Resp_Byte 0x00, o_Err_Code 0, state IDLE, timeout counter 0.
- All outputs are registered.
- Final frame byte's i_RX_DV sampled at edge N: EXEC is entered at edge N and o_Wr_En/o_Rd_En is high during cycle N→N+1 (1-cycle latency).
- i_Rd_Valid is honoured from the cycle after o_Rd_En. The cycle in which o_Rd_En is high is ignored.
- i_Rd_Valid sampled at edge M: o_Resp_DV is high during cycle M→M+1. o_Resp_Byte updates at the same edge.
- o_Err is high for the single cycle following the edge at which the error was detected. o_Err_Code updates at the same edge.
- Reset mid-frame or mid-read: the partial frame is discarded, and a pending response is dropped with no strobe.
- Timeout and a qualifying event in the same cycle: the event wins, and no error is raised.
- A byte arriving on the cycle RESPOND returns to IDLE counts as overrun. IDLE accepts bytes from the following cycle.
- Back-to-back frames need no idle gap once the controller is back in IDLE.

## Configuration
- Macro UART_CMD_CHECKSUM_EN, defined: 5-byte frame as above, and error 2 is possible.
- Not defined: 4-byte frame (no CHK byte). GET_DATA moves directly to EXEC, the GET_CHK state is not built, and error 2 never occurs.

## Structure
- Package uart_cmd_pkg holds:
  - the state enum;
  - SYNC_BYTE 0xA5, CMD_WR 0x01, CMD_RD 0x02;
  - the error-code constants (3-bit localparams).
- One sub-module, uart_cmd_timeout, implements the timeout counter.
  - Parameter TIMEOUT_CLKS.
  - Inputs i_Clock, i_Reset, i_Clear, i_Run. Output o_Expired (one cycle).

## Test plan
- Write A5 01 10 5C 4D (CHK 0x4D): one o_Wr_En with o_Addr=0x10, o_Wr_Data=0x5C, 1 cycle after the last i_RX_DV; no o_Err.
- Read A5 02 20 00 22, then i_Rd_Valid with i_Rd_Data=0x3C three cycles after o_Rd_En: o_Rd_En with o_Addr=0x20, then o_Resp_DV with o_Resp_Byte=0x3C; no write.
- A5 01 10 5C 00 (bad CHK): o_Err, o_Err_Code=2, no strobe. A following valid frame executes normally. Without UART_CMD_CHECKSUM_EN, A5 01 10 5C writes, and 0x00 is discarded in IDLE.
- A5 07: o_Err code 1. Leading bytes 00 FF before A5 01 10 5C 4D: no error, one write.
- A5 01 then no bytes for TIMEOUT_CLKS cycles: o_Err code 3, back in IDLE. A read with i_Rd_Valid never asserted: code 4 and no o_Resp_DV.
- Byte during WAIT_RD: code 5, and the response is still delivered. i_Reset after A5 01 10: all outputs 0, the next full frame executes.
